// File: rtl/sram_phase_sequencer.sv
// sram_phase_sequencer: top-level phase controller and SRAM access mux.
// Walks IDLE (VGA owns SRAM) -> UART receive -> each unskipped decode stage
// in ascending order -> IDLE, granting the SRAM port to exactly one client
// per phase. Includes an optional per-stage watchdog and an abort input.
module sram_phase_sequencer #(
  parameter int NUM_STAGES   = 3,
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int TIMER_W      = 26,
  parameter int UART_TIMEOUT = 49_999_999,
  parameter int STAGE_WDOG   = 0
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         UART_RX_I,
  input  logic                         Abort,
  input  logic [NUM_STAGES-1:0]        Skip_mask,
  input  logic [ADDR_W-1:0]            VGA_address,
  input  logic [ADDR_W-1:0]            UART_address,
  input  logic [DATA_W-1:0]            UART_write_data,
  input  logic                         UART_we_n,
  input  logic [NUM_STAGES*ADDR_W-1:0] Stage_address,
  input  logic [NUM_STAGES*DATA_W-1:0] Stage_write_data,
  input  logic [NUM_STAGES-1:0]        Stage_we_n,
  input  logic [NUM_STAGES-1:0]        Stage_done,
  output logic [NUM_STAGES-1:0]        Stage_start,
  output logic                         UART_rx_initialize,
  output logic                         UART_rx_enable,
  output logic                         VGA_enable,
  output logic [ADDR_W-1:0]            SRAM_address,
  output logic [DATA_W-1:0]            SRAM_write_data,
  output logic                         SRAM_we_n,
  output logic [2:0]                   Active_stage,
  output logic                         Wdog_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UART_RX,
    S_STAGE_START,
    S_STAGE_RUN
  } state_t;

  localparam logic [TIMER_W-1:0] UART_LIMIT = TIMER_W'(UART_TIMEOUT);
  localparam logic [TIMER_W-1:0] WDOG_LIMIT = TIMER_W'(STAGE_WDOG - 1);
  localparam bit                 WDOG_ON    = (STAGE_WDOG != 0);

  state_t                  state_q, state_n;
  logic [TIMER_W-1:0]      timer_q, timer_n, timer_inc;
  logic [2:0]              active_q, active_n;
  logic [NUM_STAGES-1:0]   start_q, start_n;
  logic                    rx_init_q, rx_init_n;
  logic                    rx_en_q, rx_en_n;
  logic                    vga_en_q, vga_en_n;
  logic                    wdog_q, wdog_n;
  logic                    active_done;
  logic [3:0]              first_pick, next_pick;

  // Lowest unskipped stage index >= from; bit 3 flags that one was found.
  function automatic logic [3:0] pick_stage(input logic [NUM_STAGES-1:0] skip,
                                            input int from);
    logic [3:0] pick;
    pick = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (k >= from && !skip[k]) pick = {1'b1, 3'(k)};
    end
    return pick;
  endfunction

  // Saturating increment so a long-idle timer never wraps back to a match.
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);

  // Done bit of the currently active stage; other stages' done bits are ignored.
  always_comb begin
    active_done = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (active_q == 3'(k)) active_done = Stage_done[k];
    end
  end

  // Next-state and next-output logic; abort overrides every transition.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_n    = state_q;
    timer_n    = timer_q;
    active_n   = active_q;
    wdog_n     = wdog_q;
    rx_init_n  = 1'b0;
    first_pick = pick_stage(Skip_mask, 0);
    next_pick  = pick_stage(Skip_mask, int'(active_q) + 1);

    unique case (state_q)
      S_IDLE: begin
        if (!UART_RX_I) begin
          rx_init_n = 1'b1;
          timer_n   = '0;
          state_n   = S_UART_RX;
        end
      end
      S_UART_RX: begin
        // Any UART write restarts the idle timeout.
        if (!UART_we_n) begin
          timer_n = '0;
        end else if (timer_q == UART_LIMIT) begin
          timer_n = '0;
          if (first_pick[3]) begin
            active_n = first_pick[2:0];
            state_n  = S_STAGE_START;
          end else begin
            state_n  = S_IDLE;
          end
        end else begin
          timer_n = timer_inc;
        end
      end
      S_STAGE_START: begin
        timer_n = '0;
        state_n = S_STAGE_RUN;
      end
      S_STAGE_RUN: begin
        // Done is checked first so it wins over a watchdog expiring together.
        if (active_done) begin
          timer_n = '0;
          if (next_pick[3]) begin
            active_n = next_pick[2:0];
            state_n  = S_STAGE_START;
          end else begin
            state_n  = S_IDLE;
          end
        end else if (WDOG_ON && timer_q == WDOG_LIMIT) begin
          wdog_n  = 1'b1;
          timer_n = '0;
          state_n = S_IDLE;
        end else begin
          timer_n = timer_inc;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (Abort && state_q != S_IDLE) begin
      state_n   = S_IDLE;
      active_n  = active_q;
      rx_init_n = 1'b0;
    end

    // Receive enable follows initialize and holds while receive continues.
    rx_en_n  = (state_n == S_UART_RX) && (rx_init_q || rx_en_q);
    vga_en_n = (state_n == S_IDLE);
    start_n  = '0;
    if (state_n == S_STAGE_START) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (active_n == 3'(k)) start_n[k] = 1'b1;
      end
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      active_q  <= '0;
      start_q   <= '0;
      rx_init_q <= 1'b0;
      rx_en_q   <= 1'b0;
      vga_en_q  <= 1'b1;
      wdog_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      timer_q   <= timer_n;
      active_q  <= active_n;
      start_q   <= start_n;
      rx_init_q <= rx_init_n;
      rx_en_q   <= rx_en_n;
      vga_en_q  <= vga_en_n;
      wdog_q    <= wdog_n;
    end
  end

  // SRAM port mux, selected purely by the current state.
  always_comb begin
    SRAM_address    = VGA_address;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    unique case (state_q)
      S_UART_RX: begin
        SRAM_address    = UART_address;
        SRAM_write_data = UART_write_data;
        SRAM_we_n       = UART_we_n;
      end
      S_STAGE_START, S_STAGE_RUN: begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (active_q == 3'(k)) begin
            SRAM_address    = Stage_address[k*ADDR_W +: ADDR_W];
            SRAM_write_data = Stage_write_data[k*DATA_W +: DATA_W];
            SRAM_we_n       = Stage_we_n[k];
          end
        end
      end
      default: ;
    endcase
  end

  assign Stage_start        = start_q;
  assign UART_rx_initialize = rx_init_q;
  assign UART_rx_enable     = rx_en_q;
  assign VGA_enable         = vga_en_q;
  assign Active_stage       = active_q;
  assign Wdog_error         = wdog_q;

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// Directed testbench for sram_phase_sequencer with a 100-cycle UART timeout,
// a 20-cycle stage watchdog and three stages.
module tb_sram_phase_sequencer;

  localparam int NS = 3;
  localparam int AW = 18;
  localparam int DW = 16;

  localparam logic [AW-1:0] VGA_A  = 18'h0A0A0;
  localparam logic [AW-1:0] UART_A = 18'h01111;
  localparam logic [DW-1:0] UART_D = 16'hBEEF;

  // Bus snapshots are {address, write data, we_n}.
  localparam logic [AW+DW:0] VGA_BUS  = {VGA_A, 16'h0000, 1'b1};
  localparam logic [AW+DW:0] UART_BUS = {UART_A, UART_D, 1'b1};
  localparam logic [AW+DW:0] S0_BUS   = {18'h3C000, 16'hD000, 1'b1};
  localparam logic [AW+DW:0] S1_BUS   = {18'h3C001, 16'hD001, 1'b0};
  localparam logic [AW+DW:0] S2_BUS   = {18'h3C002, 16'hD002, 1'b1};

  logic              Clock = 1'b0;
  logic              Reset, UART_RX_I, Abort, UART_we_n;
  logic [NS-1:0]     Skip_mask, Stage_we_n, Stage_done, Stage_start;
  logic [AW-1:0]     VGA_address, UART_address, SRAM_address;
  logic [DW-1:0]     UART_write_data, SRAM_write_data;
  logic [NS*AW-1:0]  Stage_address;
  logic [NS*DW-1:0]  Stage_write_data;
  logic              UART_rx_initialize, UART_rx_enable, VGA_enable, SRAM_we_n, Wdog_error;
  logic [2:0]        Active_stage;

  int            checks = 0;
  int            errors = 0;
  logic [NS-1:0] start_seen;

  always #5 Clock = ~Clock;

  sram_phase_sequencer #(
    .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMER_W(26),
    .UART_TIMEOUT(100), .STAGE_WDOG(20)
  ) dut (
    .Clock(Clock), .Reset(Reset), .UART_RX_I(UART_RX_I), .Abort(Abort),
    .Skip_mask(Skip_mask), .VGA_address(VGA_address), .UART_address(UART_address),
    .UART_write_data(UART_write_data), .UART_we_n(UART_we_n),
    .Stage_address(Stage_address), .Stage_write_data(Stage_write_data),
    .Stage_we_n(Stage_we_n), .Stage_done(Stage_done), .Stage_start(Stage_start),
    .UART_rx_initialize(UART_rx_initialize), .UART_rx_enable(UART_rx_enable),
    .VGA_enable(VGA_enable), .SRAM_address(SRAM_address),
    .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
    .Active_stage(Active_stage), .Wdog_error(Wdog_error)
  );

  // {VGA_enable, UART_rx_initialize, UART_rx_enable, Wdog_error, Stage_start}
  function automatic logic [6:0] flags();
    return {VGA_enable, UART_rx_initialize, UART_rx_enable, Wdog_error, Stage_start};
  endfunction

  function automatic logic [AW+DW:0] bus();
    return {SRAM_address, SRAM_write_data, SRAM_we_n};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
    start_seen = start_seen | Stage_start;
  endtask

  task automatic enter_uart();
    UART_RX_I = 1'b0;
    tick();
    UART_RX_I = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; UART_RX_I = 1'b1; Abort = 1'b0; Skip_mask = '0;
    UART_we_n = 1'b1; Stage_done = '0;
    repeat (2) tick();
    Reset = 1'b0;
    checks++;
    if (flags() !== 7'b1000000) begin
      errors++; $display("FAIL reset_flags: got %b expected %b", flags(), 7'b1000000);
    end
    checks++;
    if (bus() !== VGA_BUS) begin
      errors++; $display("FAIL reset_bus: got %h expected %h", bus(), VGA_BUS);
    end
    checks++;
    if (Active_stage !== 3'd0) begin
      errors++; $display("FAIL reset_active: got %0d expected 0", Active_stage);
    end
    tick();
    checks++;
    if (flags() !== 7'b1000000) begin
      errors++; $display("FAIL idle_hold: got %b expected %b", flags(), 7'b1000000);
    end
  endtask

  task automatic test_uart_entry();
    enter_uart();
    checks++;
    if (flags() !== 7'b0100000) begin
      errors++; $display("FAIL uart_init: got %b expected %b", flags(), 7'b0100000);
    end
    checks++;
    if (bus() !== UART_BUS) begin
      errors++; $display("FAIL uart_bus: got %h expected %h", bus(), UART_BUS);
    end
    tick();
    checks++;
    if (flags() !== 7'b0010000) begin
      errors++; $display("FAIL uart_enable: got %b expected %b", flags(), 7'b0010000);
    end
  endtask

  // Write pulse at cycle 50 of receive; stage start lands 101 cycles later.
  task automatic test_uart_timeout();
    repeat (48) tick();
    UART_we_n = 1'b0;
    #1;
    checks++;
    if (SRAM_we_n !== 1'b0) begin
      errors++; $display("FAIL uart_we_pass: got %b expected 0", SRAM_we_n);
    end
    tick();
    UART_we_n = 1'b1;
    repeat (100) tick();
    checks++;
    if ({VGA_enable, bus()} !== {1'b0, UART_BUS}) begin
      errors++; $display("FAIL uart_before_timeout: got %h expected %h", {VGA_enable, bus()}, {1'b0, UART_BUS});
    end
    tick();
    checks++;
    if (flags() !== 7'b0000001) begin
      errors++; $display("FAIL timeout_start: got %b expected %b", flags(), 7'b0000001);
    end
    checks++;
    if ({Active_stage, bus()} !== {3'd0, S0_BUS}) begin
      errors++; $display("FAIL stage0_bus: got %h expected %h", {Active_stage, bus()}, {3'd0, S0_BUS});
    end
    tick();
    checks++;
    if (flags() !== 7'b0000000) begin
      errors++; $display("FAIL start_one_cycle: got %b expected %b", flags(), 7'b0000000);
    end
  endtask

  task automatic test_abort();
    Stage_done = 3'b001;
    tick();
    Stage_done = '0;
    checks++;
    if ({flags(), Active_stage, bus()} !== {7'b0000010, 3'd1, S1_BUS}) begin
      errors++; $display("FAIL stage1_start: got %h expected %h", {flags(), Active_stage, bus()}, {7'b0000010, 3'd1, S1_BUS});
    end
    tick();
    Abort = 1'b1; Stage_done = 3'b010;
    tick();
    Abort = 1'b0; Stage_done = '0;
    checks++;
    if ({flags(), bus()} !== {7'b1000000, VGA_BUS}) begin
      errors++; $display("FAIL abort_idle: got %h expected %h", {flags(), bus()}, {7'b1000000, VGA_BUS});
    end
    tick();
    checks++;
    if (flags() !== 7'b1000000) begin
      errors++; $display("FAIL abort_done_ignored: got %b expected %b", flags(), 7'b1000000);
    end
  endtask

  task automatic test_skip();
    Skip_mask = 3'b010;
    start_seen = '0;
    enter_uart();
    repeat (101) tick();
    checks++;
    if ({flags(), bus()} !== {7'b0000001, S0_BUS}) begin
      errors++; $display("FAIL skip_stage0: got %h expected %h", {flags(), bus()}, {7'b0000001, S0_BUS});
    end
    tick();
    Stage_done = 3'b001;
    tick();
    Stage_done = '0;
    checks++;
    if ({flags(), Active_stage, bus()} !== {7'b0000100, 3'd2, S2_BUS}) begin
      errors++; $display("FAIL skip_stage2: got %h expected %h", {flags(), Active_stage, bus()}, {7'b0000100, 3'd2, S2_BUS});
    end
    tick();
    Stage_done = 3'b100;
    tick();
    Stage_done = '0;
    checks++;
    if ({flags(), bus()} !== {7'b1000000, VGA_BUS}) begin
      errors++; $display("FAIL skip_last_idle: got %h expected %h", {flags(), bus()}, {7'b1000000, VGA_BUS});
    end
    checks++;
    if (start_seen !== 3'b101) begin
      errors++; $display("FAIL skip_starts_seen: got %b expected 101", start_seen);
    end
  endtask

  task automatic test_watchdog();
    Skip_mask = '0;
    enter_uart();
    repeat (101) tick();
    tick();
    repeat (19) tick();
    checks++;
    if (flags() !== 7'b0000000) begin
      errors++; $display("FAIL wdog_cycle19: got %b expected %b", flags(), 7'b0000000);
    end
    tick();
    checks++;
    if ({flags(), bus()} !== {7'b1001000, VGA_BUS}) begin
      errors++; $display("FAIL wdog_fire: got %h expected %h", {flags(), bus()}, {7'b1001000, VGA_BUS});
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (flags() !== 7'b1000000) begin
      errors++; $display("FAIL wdog_reset_clear: got %b expected %b", flags(), 7'b1000000);
    end
    enter_uart();
    repeat (101) tick();
    tick();
    repeat (19) tick();
    Stage_done = 3'b001;
    tick();
    Stage_done = '0;
    checks++;
    if ({flags(), Active_stage} !== {7'b0000010, 3'd1}) begin
      errors++; $display("FAIL wdog_done_wins: got %h expected %h", {flags(), Active_stage}, {7'b0000010, 3'd1});
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if ({flags(), Active_stage, bus()} !== {7'b1000000, 3'd0, VGA_BUS}) begin
      errors++; $display("FAIL reset_mid_phase: got %h expected %h", {flags(), Active_stage, bus()}, {7'b1000000, 3'd0, VGA_BUS});
    end
  endtask

  task automatic test_all_skipped();
    Skip_mask = 3'b111;
    start_seen = '0;
    enter_uart();
    repeat (100) tick();
    checks++;
    if (VGA_enable !== 1'b0) begin
      errors++; $display("FAIL allskip_in_uart: got %b expected 0", VGA_enable);
    end
    tick();
    checks++;
    if ({flags(), bus()} !== {7'b1000000, VGA_BUS}) begin
      errors++; $display("FAIL allskip_idle: got %h expected %h", {flags(), bus()}, {7'b1000000, VGA_BUS});
    end
    checks++;
    if (start_seen !== 3'b000) begin
      errors++; $display("FAIL allskip_no_start: got %b expected 000", start_seen);
    end
  endtask

  initial begin
    VGA_address      = VGA_A;
    UART_address     = UART_A;
    UART_write_data  = UART_D;
    Stage_address    = {18'h3C002, 18'h3C001, 18'h3C000};
    Stage_write_data = {16'hD002, 16'hD001, 16'hD000};
    Stage_we_n       = 3'b101;
    start_seen       = '0;
    test_reset();
    test_uart_entry();
    test_uart_timeout();
    test_abort();
    test_skip();
    test_watchdog();
    test_all_skipped();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
